dip_debounce_ctrl: RTL and testbench

Memory-mapped controller for the 24-bit DIP switch bank on the SoC peripheral bus. It synchronises the raw switch inputs and debounces them with a single shared counter FSM. It then commits a stable snapshot for the CPU to read. It also tracks which bits changed since the last status read, with a clear-on-read status register and a maskable interrupt.

---
 rtl/dip_debounce_ctrl.sv | 152 +++++++++++++++
 tb/tb_dip_debounce_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dip_debounce_ctrl.sv
// Memory-mapped DIP switch controller: two-flop synchroniser, shared-counter debounce FSM,
// stable snapshot, clear-on-read change status and maskable irq. Optional macro: DIP_COMMIT_CNT_EN.
module dip_debounce_ctrl #(
   parameter logic [11:0] DATAADDR   = 12'h070,
   parameter logic [11:0] STATADDR   = 12'h074,
   parameter logic [11:0] CTRLADDR   = 12'h078,
   parameter logic [11:0] CNTADDR    = 12'h07C,
   parameter int unsigned DEB_CYCLES = 100000,
   parameter int unsigned CNT_W      = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rd_ena,
   input  logic        wr_ena,
   input  logic [11:0] dv_addr,
   input  logic [31:0] wdata,
   input  logic [23:0] switch,
   output logic [31:0] data_tocpu,
   output logic        irq
);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      COMMIT
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   state_t           state_q, state_d;
   logic [23:0]      sync1_q, sync2_q;
   logic [23:0]      cand_q, cand_d;
   logic [23:0]      stable_q, stable_d;
   logic [23:0]      changed_q, changed_d;
   logic             chg_flag_q, chg_flag_d;
   logic             irq_en_q, irq_en_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stat_rd;
   logic             unused_wdata;

   assign stat_rd      = rd_ena && (dv_addr == STATADDR);
   assign unused_wdata = ^wdata[31:1];

   // NOTE: every register is written with <= so all flops sample pre-edge values together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sync1_q    <= '0;
         sync2_q    <= '0;
         cand_q     <= '0;
         stable_q   <= '0;
         changed_q  <= '0;
         chg_flag_q <= 1'b0;
         irq_en_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= switch;
         sync2_q    <= sync1_q;
         cand_q     <= cand_d;
         stable_q   <= stable_d;
         changed_q  <= changed_d;
         chg_flag_q <= chg_flag_d;
         irq_en_q   <= irq_en_d;
         cnt_q      <= cnt_d;
      end
   end

   // NOTE: hold values are assigned first so no path through this block can infer a latch.
   always_comb begin
      state_d    = state_q;
      cand_d     = cand_q;
      stable_d   = stable_q;
      changed_d  = changed_q;
      chg_flag_d = chg_flag_q;
      irq_en_d   = irq_en_q;
      cnt_d      = cnt_q;

      // Clear first so a coinciding commit re-sets the flag with only its own bits.
      if (stat_rd) begin
         changed_d  = '0;
         chg_flag_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (sync2_q != stable_q) begin
               cand_d  = sync2_q;
               cnt_d   = '0;
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (sync2_q == stable_q) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (sync2_q != cand_q) begin
               cand_d = sync2_q;
               cnt_d  = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = COMMIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         COMMIT: begin
            stable_d   = cand_q;
            changed_d  = changed_d | (cand_q ^ stable_q);
            chg_flag_d = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (wr_ena && (dv_addr == CTRLADDR)) begin
         irq_en_d = wdata[0];
      end
   end

`ifdef DIP_COMMIT_CNT_EN
   logic [15:0] commit_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         commit_cnt_q <= '0;
      end else if (state_q == COMMIT) begin
         commit_cnt_q <= commit_cnt_q + 16'd1;
      end
   end
`endif

   always_comb begin
      data_tocpu = '0;
      if (rd_ena) begin
         case (dv_addr)
            DATAADDR: data_tocpu = {8'b0, stable_q};
            STATADDR: data_tocpu = {chg_flag_q, 7'b0, changed_q};
            CTRLADDR: data_tocpu = {31'b0, irq_en_q};
`ifdef DIP_COMMIT_CNT_EN
            CNTADDR:  data_tocpu = {16'b0, commit_cnt_q};
`else
            CNTADDR:  data_tocpu = '0;
`endif
            default:  data_tocpu = '0;
         endcase
      end
   end

   assign irq = chg_flag_q & irq_en_q;

endmodule

// File: tb/tb_dip_debounce_ctrl.sv
// Self-checking bench for dip_debounce_ctrl (DEB_CYCLES=4): directed scenarios plus randomized
// traffic compared against a run-length reference model of the debounce behaviour.
module tb_dip_debounce_ctrl;

   localparam int          DEB  = 4;
   localparam logic [11:0] A_DATA = 12'h070;
   localparam logic [11:0] A_STAT = 12'h074;
   localparam logic [11:0] A_CTRL = 12'h078;
   localparam logic [11:0] A_CNT  = 12'h07C;

   logic        clk = 1'b0;
   logic        rst_n, rd_ena, wr_ena;
   logic [11:0] dv_addr;
   logic [31:0] wdata;
   logic [23:0] switch;
   logic [31:0] data_tocpu;
   logic        irq;

   int checks = 0;
   int errors = 0;

   dip_debounce_ctrl #(.DEB_CYCLES(DEB), .CNT_W(17)) dut (
      .clk(clk), .rst_n(rst_n), .rd_ena(rd_ena), .wr_ena(wr_ena), .dv_addr(dv_addr),
      .wdata(wdata), .switch(switch), .data_tocpu(data_tocpu), .irq(irq)
   );

   always #5 clk = ~clk;

   // Reference model: a commit happens one edge after the synchronised input has shown the
   // same non-stable value on DEB+1 consecutive edges; the commit edge itself is not observed.
   logic [23:0] m_s1, m_s2, m_stable, m_changed, m_runval;
   logic        m_flag, m_irq_en, m_pending;
   int          m_run, m_commits;

   task automatic model_edge(input logic r, input logic rd, input logic wr,
                             input logic [11:0] a, input logic [31:0] wd, input logic [23:0] sw);
      logic [23:0] nchg;
      logic        nflag;
      if (!r) begin
         m_s1 = 0; m_s2 = 0; m_stable = 0; m_changed = 0; m_runval = 0;
         m_flag = 0; m_irq_en = 0; m_pending = 0; m_run = 0; m_commits = 0;
         return;
      end
      nchg  = (rd && a == A_STAT) ? 24'h0 : m_changed;
      nflag = (rd && a == A_STAT) ? 1'b0 : m_flag;
      if (m_pending) begin
         nchg      = nchg | (m_runval ^ m_stable);
         nflag     = 1'b1;
         m_stable  = m_runval;
         m_pending = 0;
         m_run     = 0;
         m_commits++;
      end else if (m_s2 == m_stable) begin
         m_run = 0;
      end else if (m_run != 0 && m_s2 == m_runval) begin
         m_run++;
      end else begin
         m_runval = m_s2;
         m_run    = 1;
      end
      if (m_run == DEB + 1) m_pending = 1;
      m_changed = nchg;
      m_flag    = nflag;
      if (wr && a == A_CTRL) m_irq_en = wd[0];
      m_s2 = m_s1;
      m_s1 = sw;
   endtask

   function automatic logic [31:0] model_read(input logic rd, input logic [11:0] a);
      if (!rd) return 32'h0;
      case (a)
         A_DATA:  return {8'h0, m_stable};
         A_STAT:  return {m_flag, 7'h0, m_changed};
         A_CTRL:  return {31'h0, m_irq_en};
`ifdef DIP_COMMIT_CNT_EN
         A_CNT:   return {16'h0, m_commits[15:0]};
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic tick();
      logic        r  = rst_n;
      logic        rd = rd_ena;
      logic        wr = wr_ena;
      logic [11:0] a  = dv_addr;
      logic [31:0] wd = wdata;
      logic [23:0] sw = switch;
      @(posedge clk);
      model_edge(r, rd, wr, a, wd, sw);
      #1;
   endtask

   task automatic clear_status();
      rd_ena = 1; dv_addr = A_STAT;
      tick();
      rd_ena = 0;
   endtask

   task automatic settle_to(input logic [23:0] v);
      switch = v;
      repeat (12) tick();
      clear_status();
   endtask

   task automatic test_reset();
      rst_n = 0; rd_ena = 0; wr_ena = 0; dv_addr = 0; wdata = 0; switch = 24'hABCDEF;
      repeat (3) tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
      rd_ena = 1; dv_addr = A_DATA; #1;
      checks++;
      if (data_tocpu !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_tocpu); end
      rd_ena = 0; rst_n = 1;
      repeat (7) tick();
      rd_ena = 1; dv_addr = A_DATA; #1;
      checks++;
      if (data_tocpu !== 32'h0) begin errors++; $display("FAIL reset_early_commit got=%h exp=0", data_tocpu); end
      tick();
      checks++;
      if (data_tocpu !== 32'h00ABCDEF) begin errors++; $display("FAIL reset_data_after8 got=%h exp=00abcdef", data_tocpu); end
      dv_addr = A_STAT; #1;
      checks++;
      if (data_tocpu !== 32'h80ABCDEF) begin errors++; $display("FAIL reset_stat got=%h exp=80abcdef", data_tocpu); end
      rd_ena = 0;
   endtask

   task automatic test_clean_step();
      int edges = 0;
      settle_to(24'h0);
      switch = 24'h000001; rd_ena = 1; dv_addr = A_DATA;
      for (int i = 1; i <= 20 && edges == 0; i++) begin
         tick();
         if (data_tocpu !== 32'h0) edges = i;
      end
      checks++;
      if (edges != DEB + 4) begin errors++; $display("FAIL step_latency got=%0d exp=%0d", edges, DEB + 4); end
      checks++;
      if (data_tocpu !== 32'h1) begin errors++; $display("FAIL step_data got=%h exp=00000001", data_tocpu); end
      dv_addr = A_STAT; #1;
      checks++;
      if (data_tocpu !== 32'h80000001) begin errors++; $display("FAIL step_stat got=%h exp=80000001", data_tocpu); end
      rd_ena = 0;
   endtask

   task automatic test_bounce();
      clear_status();
      rd_ena = 1; dv_addr = A_DATA;
      for (int i = 0; i < 20; i++) begin
         switch = ((i >> 1) & 1) != 0 ? 24'h000009 : 24'h000001;
         tick();
         checks++;
         if (data_tocpu !== 32'h1) begin errors++; $display("FAIL bounce_data cyc=%0d got=%h exp=00000001", i, data_tocpu); end
      end
      switch = 24'h000001;
      repeat (10) tick();
      dv_addr = A_STAT; #1;
      checks++;
      if (data_tocpu !== 32'h0) begin errors++; $display("FAIL bounce_stat got=%h exp=0", data_tocpu); end
      rd_ena = 0;
   endtask

   task automatic test_restart();
      int edges = 0;
      settle_to(24'h0);
      switch = 24'h000010;
      repeat (2) tick();
      switch = 24'h000030; rd_ena = 1; dv_addr = A_DATA;
      for (int i = 1; i <= 20 && edges == 0; i++) begin
         tick();
         if (data_tocpu !== 32'h0) edges = i;
      end
      checks++;
      if (edges != DEB + 4 || data_tocpu !== 32'h30) begin
         errors++; $display("FAIL restart_commit edges=%0d data=%h exp edges=%0d data=00000030", edges, data_tocpu, DEB + 4);
      end
      dv_addr = A_STAT; #1;
      checks++;
      if (data_tocpu !== 32'h80000030) begin errors++; $display("FAIL restart_stat got=%h exp=80000030", data_tocpu); end
      rd_ena = 0;
   endtask

   task automatic test_irq_clear();
      clear_status();
      wr_ena = 1; dv_addr = A_CTRL; wdata = 32'h1;
      tick();
      wr_ena = 0; wdata = 0; rd_ena = 1; #1;
      checks++;
      if (data_tocpu !== 32'h1) begin errors++; $display("FAIL ctrl_read got=%h exp=00000001", data_tocpu); end
      rd_ena = 0; switch = 24'h000100;
      repeat (DEB + 3) tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", irq); end
      tick();
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", irq); end
      rd_ena = 1; dv_addr = A_STAT; #1;
      checks++;
      if (data_tocpu !== 32'h80000130) begin errors++; $display("FAIL irq_stat got=%h exp=80000130", data_tocpu); end
      tick();
      checks++;
      if (irq !== 1'b0 || data_tocpu !== 32'h0) begin
         errors++; $display("FAIL clear_on_read irq=%b stat=%h exp irq=0 stat=0", irq, data_tocpu);
      end
      rd_ena = 0;
      switch = 24'h000101;
      repeat (12) tick();
      switch = 24'h000103;
      repeat (DEB + 3) tick();
      rd_ena = 1; dv_addr = A_STAT; #1;
      checks++;
      if (data_tocpu !== 32'h80000001) begin errors++; $display("FAIL pre_collide_stat got=%h exp=80000001", data_tocpu); end
      tick();
      checks++;
      if (data_tocpu !== 32'h80000002 || irq !== 1'b1) begin
         errors++; $display("FAIL read_commit_collide stat=%h irq=%b exp stat=80000002 irq=1", data_tocpu, irq);
      end
      rd_ena = 0;
   endtask

   task automatic test_commit_cnt();
      logic [31:0] exp;
      rst_n = 0; switch = 24'h0;
      repeat (2) tick();
      rst_n = 1;
      switch = 24'h000001; repeat (12) tick();
      switch = 24'h000003; repeat (12) tick();
      switch = 24'h000007; repeat (12) tick();
`ifdef DIP_COMMIT_CNT_EN
      exp = 32'h3;
`else
      exp = 32'h0;
`endif
      rd_ena = 1; dv_addr = A_CNT; #1;
      checks++;
      if (data_tocpu !== exp) begin errors++; $display("FAIL commit_cnt got=%h exp=%h", data_tocpu, exp); end
      rd_ena = 0;
   endtask

   task automatic test_random();
      logic [11:0] addrs [5] = '{A_DATA, A_STAT, A_CTRL, A_CNT, 12'h07F};
      logic [23:0] pool  [4] = '{24'h0, 24'h000001, 24'h800000, 24'hFFFFFF};
      logic [31:0] exp;
      int hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0) begin
            switch = ($urandom_range(0, 4) == 4) ? 24'($urandom) : pool[$urandom_range(0, 3)];
            hold   = ($urandom_range(0, 3) == 0) ? $urandom_range(DEB + 3, 14) : $urandom_range(1, DEB + 2);
         end
         hold--;
         rst_n   = ($urandom_range(0, 199) != 0);
         rd_ena  = $urandom_range(0, 1) == 1;
         wr_ena  = $urandom_range(0, 4) == 0;
         dv_addr = addrs[$urandom_range(0, 4)];
         wdata   = $urandom;
         #1;
         exp = model_read(rd_ena, dv_addr);
         checks++;
         if (data_tocpu !== exp) begin errors++; $display("FAIL rand_rdata cyc=%0d addr=%h got=%h exp=%h", i, dv_addr, data_tocpu, exp); end
         checks++;
         if (irq !== (m_flag & m_irq_en)) begin errors++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", i, irq, m_flag & m_irq_en); end
         tick();
      end
      rst_n = 1; rd_ena = 0; wr_ena = 0;
   endtask

   initial begin
      test_reset();
      test_clean_step();
      test_bounce();
      test_restart();
      test_irq_clear();
      test_commit_cnt();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
